// File: rtl/tx_packer_pkg.sv
// Shared constants, FSM state type and small helpers for the TX packer.
// Imported by the top-level packer and by its round-robin arbiter.
package tx_packer_pkg;

    localparam int OUT_W = 32;
    localparam logic [7:0]  HDR_MAGIC = 8'hA5;
    localparam logic [15:0] EOF_MAGIC = 16'hA5EE;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_BODY   = 2'd2,
        ST_EOF    = 2'd3
    } state_t;

    // Highest set bit wins; callers only pass one-hot or zero vectors.
    function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
        logic [3:0] idx;
        idx = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/tx_packer_rr_arbiter.sv
// Round-robin arbiter: grants the lowest requesting index above the last
// granted one, wrapping to index 0; the pointer moves only on update.
module rr_arbiter
    import tx_packer_pkg::*;
#(
    parameter int NUM_CH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic              update,
    output logic [NUM_CH-1:0] grant
);

    logic [3:0] last_r;

    // Last-granted pointer; reset to NUM_CH-1 so channel 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_r <= 4'(NUM_CH - 1);
        end else if (update) begin
            last_r <= onehot_to_idx(16'(grant));
        end else begin
            last_r <= last_r;
        end
    end

    // Two passes: indices above the pointer first, then the wrapped range.
    always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        for (int j = 0; j < NUM_CH; j++) begin
            grant[j] = !found && req[j] && (4'(j) > last_r);
            found    = found | grant[j];
        end
        for (int j = 0; j < NUM_CH; j++) begin
            grant[j] = grant[j] | (!found && req[j] && (4'(j) <= last_r));
            found    = found | grant[j];
        end
    end

endmodule

// File: rtl/tx_packer.sv
// Packs per-channel wide beats into 32-bit FIFO words: optional header,
// MSW-first body words, and a merged end-of-frame marker word.
module tx_packer
    import tx_packer_pkg::*;
#(
    parameter int IN_W   = 128,
    parameter int NUM_CH = 2,
    parameter int HDR_EN = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_CH*IN_W-1:0] ch_data,
    input  logic [NUM_CH-1:0]      ch_valid,
    output logic [NUM_CH-1:0]      ch_ready,
    input  logic                   frame_done,
    input  logic                   FIFO_tx_full,
    output logic [OUT_W-1:0]       FIFO_tx_din,
    output logic                   FIFO_tx_enable,
    output logic                   busy
);

    localparam int BEATS = IN_W / OUT_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    state_t            state_r;
    state_t            next_state_s;
    logic [NUM_CH-1:0] grant_s;
    logic              accept_s;
    logic              wr_s;
    logic [IN_W-1:0]   cap_data_s;
    logic [IN_W-1:0]   shift_r;
    logic [OUT_W-1:0]  hdr_word_r;
    logic [15:0]       seq_r;
    logic [15:0]       frame_cnt_r;
    logic              eof_pending_r;
    logic [CNT_W-1:0]  beat_cnt_r;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (ch_valid),
        .update (accept_s),
        .grant  (grant_s)
    );

    // Accept strobe exists only in IDLE and never while reset is asserted.
    always_comb begin
        ch_ready = '0;
        if (rst_n && (state_r == ST_IDLE)) begin
            ch_ready = grant_s;
        end else begin
            ch_ready = '0;
        end
    end

    assign accept_s       = |ch_ready;
    assign wr_s           = (state_r != ST_IDLE) && !FIFO_tx_full;
    assign FIFO_tx_enable = wr_s;
    assign busy           = (state_r != ST_IDLE) || eof_pending_r;

    // Select the granted channel's beat.
    always_comb begin
        cap_data_s = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cap_data_s = cap_data_s | (ch_data[k*IN_W +: IN_W] & {IN_W{grant_s[k]}});
        end
    end

    // Pending output word is derived from the current state's registers.
    always_comb begin
        FIFO_tx_din = '0;
        case (state_r)
            ST_HEADER: FIFO_tx_din = hdr_word_r;
            ST_BODY:   FIFO_tx_din = shift_r[IN_W-1 -: OUT_W];
            ST_EOF:    FIFO_tx_din = {EOF_MAGIC, frame_cnt_r};
            default:   FIFO_tx_din = '0;
        endcase
    end

    // Next-state logic; a blocked FIFO holds the state.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_state_s = (HDR_EN != 0) ? ST_HEADER : ST_BODY;
                end else if (eof_pending_r) begin
                    next_state_s = ST_EOF;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_HEADER: begin
                if (wr_s) begin
                    next_state_s = ST_BODY;
                end else begin
                    next_state_s = ST_HEADER;
                end
            end
            ST_BODY: begin
                if (wr_s && (beat_cnt_r == CNT_W'(BEATS - 1))) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_BODY;
                end
            end
            ST_EOF: begin
                if (wr_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_EOF;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Datapath: capture on accept, shift per body word, sequence/frame counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r       <= '0;
            hdr_word_r    <= '0;
            seq_r         <= 16'h0000;
            frame_cnt_r   <= 16'h0000;
            eof_pending_r <= 1'b0;
            beat_cnt_r    <= '0;
        end else begin
            if (accept_s) begin
                shift_r    <= cap_data_s;
                hdr_word_r <= {HDR_MAGIC, 4'h0, onehot_to_idx(16'(grant_s)), seq_r};
                seq_r      <= seq_r + 16'd1;
                beat_cnt_r <= '0;
            end else if (wr_s && (state_r == ST_BODY)) begin
                shift_r    <= shift_r << OUT_W;
                beat_cnt_r <= beat_cnt_r + CNT_W'(1);
            end
            // A new pulse in the same cycle as the marker write re-arms it.
            if (frame_done) begin
                eof_pending_r <= 1'b1;
            end else if (wr_s && (state_r == ST_EOF)) begin
                eof_pending_r <= 1'b0;
            end
            if (wr_s && (state_r == ST_EOF)) begin
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_tx_packer.sv
// Directed bench for tx_packer (NUM_CH=2, IN_W=128, HDR_EN=1): a per-cycle
// vector table plus hand-written multi-cycle sequences.
module tb_tx_packer;

    localparam logic [127:0] CH0_DATA = 128'h11112222_33334444_55556666_77778888;
    localparam logic [127:0] CH1_DATA = 128'hAAAA0001_AAAA0002_AAAA0003_AAAA0004;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [255:0] ch_data;
    logic [1:0]   ch_valid = 2'b00;
    logic [1:0]   ch_ready;
    logic         frame_done = 1'b0;
    logic         fifo_full = 1'b0;
    logic [31:0]  fifo_din;
    logic         fifo_en;
    logic         busy;

    int checks = 0;
    int errors = 0;
    logic [31:0] wq[$];
    logic [1:0]  gq[$];

    typedef struct {
        logic [1:0]  valid;
        logic        full;
        logic [1:0]  e_ready;
        logic        e_en;
        logic        chk_din;
        logic [31:0] e_din;
        logic        e_busy;
    } vec_t;

    vec_t vt[17];

    assign ch_data = {CH1_DATA, CH0_DATA};

    tx_packer #(.IN_W(128), .NUM_CH(2), .HDR_EN(1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ch_data        (ch_data),
        .ch_valid       (ch_valid),
        .ch_ready       (ch_ready),
        .frame_done     (frame_done),
        .FIFO_tx_full   (fifo_full),
        .FIFO_tx_din    (fifo_din),
        .FIFO_tx_enable (fifo_en),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && fifo_en) wq.push_back(fifo_din);
        if (rst_n && (ch_ready != 2'b00)) gq.push_back(ch_ready);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("idle_reached", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(input int ch);
        logic got;
        got = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (ch_ready[ch]) got = 1'b1;
            @(posedge clk);
            #1;
            if (got) begin
                ch_valid[ch] = 1'b0;
                break;
            end
        end
        chk("accept_seen", 32'(got), 32'd1);
    endtask

    // Hold both channels valid until n packets have been accepted.
    task automatic run_both(input int n);
        int acc;
        acc = 0;
        ch_valid = 2'b11;
        for (int c = 0; c < 400 && acc < n; c++) begin
            @(negedge clk);
            if (ch_ready != 2'b00) acc++;
            @(posedge clk);
            #1;
        end
        ch_valid = 2'b00;
        chk("accept_count", 32'(acc), 32'(n));
    endtask

    task automatic chk_pkt(input int base, input int ch, input logic [15:0] seq);
        logic [127:0] d;
        d = (ch == 1) ? CH1_DATA : CH0_DATA;
        if (wq.size() < base + 5) begin
            chk("pkt_words_present", 32'(wq.size()), 32'(base + 5));
        end else begin
            chk("pkt_header", wq[base], {8'hA5, 4'h0, 4'(ch), seq});
            for (int k = 0; k < 4; k++) begin
                chk("pkt_body", wq[base+1+k], d[127-32*k -: 32]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0]  = '{2'b01, 1'b0, 2'b01, 1'b0, 1'b0, 32'h0,        1'b0};
        vt[1]  = '{2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 32'hA5000000, 1'b1};
        vt[2]  = '{2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 32'h11112222, 1'b1};
        vt[3]  = '{2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 32'h33334444, 1'b1};
        vt[4]  = '{2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 32'h55556666, 1'b1};
        vt[5]  = '{2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 32'h77778888, 1'b1};
        vt[6]  = '{2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0,        1'b0};
        vt[7]  = '{2'b10, 1'b0, 2'b10, 1'b0, 1'b0, 32'h0,        1'b0};
        vt[8]  = '{2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 32'hA5010001, 1'b1};
        vt[9]  = '{2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 32'hAAAA0001, 1'b1};
        vt[10] = '{2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 32'hAAAA0002, 1'b1};
        vt[11] = '{2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 32'hAAAA0002, 1'b1};
        vt[12] = '{2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 32'hAAAA0002, 1'b1};
        vt[13] = '{2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 32'hAAAA0002, 1'b1};
        vt[14] = '{2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 32'hAAAA0003, 1'b1};
        vt[15] = '{2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 32'hAAAA0004, 1'b1};
        vt[16] = '{2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0,        1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ch_ready), 32'd0);
        chk("rst_en", 32'(fifo_en), 32'd0);
        chk("rst_din", fifo_din, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        // Basic packet, then a backpressured packet on channel 1
        for (int i = 0; i < 17; i++) begin
            ch_valid  = vt[i].valid;
            fifo_full = vt[i].full;
            @(negedge clk);
            chk($sformatf("vec%0d_ready", i), 32'(ch_ready), 32'(vt[i].e_ready));
            chk($sformatf("vec%0d_en", i), 32'(fifo_en), 32'(vt[i].e_en));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].e_busy));
            if (vt[i].chk_din) chk($sformatf("vec%0d_din", i), fifo_din, vt[i].e_din);
            @(posedge clk);
            #1;
        end
        chk("bp_word_count", 32'(wq.size()), 32'd10);

        // Four packets with both channels contending
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        wq.delete();
        gq.delete();
        run_both(4);
        wait_idle();
        chk("rr_grant_count", 32'(gq.size()), 32'd4);
        if (gq.size() == 4) begin
            chk("rr_g0", 32'(gq[0]), 32'd1);
            chk("rr_g1", 32'(gq[1]), 32'd2);
            chk("rr_g2", 32'(gq[2]), 32'd1);
            chk("rr_g3", 32'(gq[3]), 32'd2);
        end
        chk("rr_words", 32'(wq.size()), 32'd20);
        chk_pkt(0, 0, 16'd0);
        chk_pkt(5, 1, 16'd1);
        chk_pkt(10, 0, 16'd2);
        chk_pkt(15, 1, 16'd3);

        // Two frame_done pulses mid-packet with channel 1 waiting
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        wq.delete();
        gq.delete();
        ch_valid = 2'b01;
        wait_accept(0);
        tick();
        frame_done = 1'b1;
        ch_valid[1] = 1'b1;
        tick();
        frame_done = 1'b0;
        tick();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        chk("eof_busy_mid", 32'(busy), 32'd1);
        wait_accept(1);
        wait_idle();
        repeat (4) tick();
        chk("eof_words", 32'(wq.size()), 32'd11);
        chk_pkt(0, 0, 16'd0);
        chk_pkt(5, 1, 16'd1);
        if (wq.size() >= 11) chk("eof_marker0", wq[10], 32'hA5EE0000);
        chk("eof_busy_after", 32'(busy), 32'd0);
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        wait_idle();
        chk("eof_words2", 32'(wq.size()), 32'd12);
        if (wq.size() >= 12) chk("eof_marker1", wq[11], 32'hA5EE0001);

        // Sequence counter wrap
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        wq.delete();
        force dut.seq_r = 16'hFFFF;
        tick();
        release dut.seq_r;
        run_both(2);
        wait_idle();
        chk("wrap_words", 32'(wq.size()), 32'd10);
        chk_pkt(0, 0, 16'hFFFF);
        chk_pkt(5, 1, 16'h0000);

        // Reset in the middle of the body
        wq.delete();
        ch_valid = 2'b01;
        wait_accept(0);
        tick();
        chk("midrst_en_before", 32'(fifo_en), 32'd1);
        chk("midrst_din_before", fifo_din, 32'h11112222);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_en", 32'(fifo_en), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ready", 32'(ch_ready), 32'd0);
        chk("midrst_din", fifo_din, 32'h0);
        tick();
        rst_n = 1'b1;
        wq.delete();
        repeat (5) tick();
        chk("midrst_no_resume", 32'(wq.size()), 32'd0);
        run_both(1);
        wait_idle();
        chk("midrst_words", 32'(wq.size()), 32'd5);
        chk_pkt(0, 0, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
